// File: rtl/wb_pico_decoder_if.sv
// Wishbone pipelined bus bundle between the PicoRV32 bridge, the decoder and its NS slaves.
// The "slave" modport is the decoder's view; "master" is the surrounding environment's view.
interface wb_pico_decoder_if #(
  parameter int NS = 4
);
  logic             i_mcyc;
  logic             i_mstb;
  logic             i_mwe;
  logic [29:0]      i_maddr;
  logic [31:0]      i_mdata;
  logic [3:0]       i_msel;
  logic             o_mstall;
  logic             o_mack;
  logic             o_merr;
  logic [31:0]      o_mdata;
  logic [NS-1:0]    o_scyc;
  logic [NS-1:0]    o_sstb;
  logic             o_swe;
  logic [29:0]      o_saddr;
  logic [31:0]      o_sdata;
  logic [3:0]       o_ssel;
  logic [NS-1:0]    i_sstall;
  logic [NS-1:0]    i_sack;
  logic [NS-1:0]    i_serr;
  logic [NS*32-1:0] i_sdata;
  logic             o_timeout;

  modport slave (
    input  i_mcyc, i_mstb, i_mwe, i_maddr, i_mdata, i_msel,
    input  i_sstall, i_sack, i_serr, i_sdata,
    output o_mstall, o_mack, o_merr, o_mdata,
    output o_scyc, o_sstb, o_swe, o_saddr, o_sdata, o_ssel, o_timeout
  );

  modport master (
    output i_mcyc, i_mstb, i_mwe, i_maddr, i_mdata, i_msel,
    output i_sstall, i_sack, i_serr, i_sdata,
    input  o_mstall, o_mack, o_merr, o_mdata,
    input  o_scyc, o_sstb, o_swe, o_saddr, o_sdata, o_ssel, o_timeout
  );
endinterface

// File: rtl/wb_pico_decoder.sv
// Single-master Wishbone address decoder with bus-timeout watchdog.
// States: IDLE = ready to accept/decode | BUSY = selected slave owns the bus | ERR = unmapped, error next cycle
module wb_pico_decoder #(
  parameter int               NS         = 4,
  parameter logic [NS*30-1:0] SLAVE_ADDR = {30'h0200_0100, 30'h0200_0000, 30'h0100_0000, 30'h0000_0000},
  parameter logic [NS*30-1:0] SLAVE_MASK = {30'h3FFF_FF00, 30'h3FFF_FF00, 30'h3F00_0000, 30'h3F00_0000},
  parameter int               TIMEOUT    = 1023
) (
  input  logic              i_clk,
  input  logic              i_reset,
  wb_pico_decoder_if.slave  bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

  state_t        state_q, state_d;
  logic [NS-1:0] scyc_q, scyc_d;
  logic [NS-1:0] sstb_q, sstb_d;
  logic [NS-1:0] sel_q, dec_sel;
  logic          dec_hit;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic          to_q, to_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load, capture;
  logic          s_ack, s_err;
  logic [31:0]   rdata;
  logic [29:0]   saddr_q;
  logic [31:0]   sdata_q, mdata_q;
  logic [3:0]    ssel_q;
  logic          swe_q;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    dec_hit = 1'b0;
    dec_sel = '0;
    for (int k = NS - 1; k >= 0; k--) begin
      if ((bus.i_maddr & SLAVE_MASK[k*30 +: 30]) == (SLAVE_ADDR[k*30 +: 30] & SLAVE_MASK[k*30 +: 30])) begin
        dec_hit    = 1'b1;
        dec_sel    = '0;
        dec_sel[k] = 1'b1;
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int k = 0; k < NS; k++) begin
      if (sel_q[k]) rdata = rdata | bus.i_sdata[k*32 +: 32];
    end
  end

  assign s_ack = |(bus.i_sack & sel_q);
  assign s_err = |(bus.i_serr & sel_q);

  always_comb begin
    state_d = state_q;
    scyc_d  = scyc_q;
    sstb_d  = sstb_q & bus.i_sstall;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    to_d    = 1'b0;
    cnt_d   = cnt_q;
    load    = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        scyc_d = '0;
        sstb_d = '0;
        if (bus.i_mcyc && bus.i_mstb) begin
          load  = 1'b1;
          cnt_d = '0;
          if (dec_hit) begin
            scyc_d  = dec_sel;
            sstb_d  = dec_sel;
            state_d = BUSY;
          end else begin
            state_d = ERR;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (!bus.i_mcyc || s_err || s_ack || (cnt_q == CW'(TIMEOUT))) begin
          state_d = IDLE;
          scyc_d  = '0;
          sstb_d  = '0;
        end
        // Abort suppresses any response; err beats ack; the watchdog only fires when the slave is silent.
        if (bus.i_mcyc) begin
          if (s_err) begin
            err_d = 1'b1;
          end else if (s_ack) begin
            ack_d   = 1'b1;
            capture = 1'b1;
          end else if (cnt_q == CW'(TIMEOUT)) begin
            err_d = 1'b1;
            to_d  = 1'b1;
          end
        end
      end
      ERR: begin
        scyc_d  = '0;
        sstb_d  = '0;
        err_d   = bus.i_mcyc;
        state_d = IDLE;
      end
      default: begin
        scyc_d  = '0;
        sstb_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      scyc_q  <= '0;
      sstb_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      scyc_q  <= scyc_d;
      sstb_q  <= sstb_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (load) begin
      saddr_q <= bus.i_maddr;
      sdata_q <= bus.i_mdata;
      ssel_q  <= bus.i_msel;
      swe_q   <= bus.i_mwe;
      sel_q   <= dec_sel;
    end
    if (capture) mdata_q <= rdata;
  end

  assign bus.o_mstall  = (state_q != IDLE);
  assign bus.o_mack    = ack_q & bus.i_mcyc;
  assign bus.o_merr    = err_q & bus.i_mcyc;
  assign bus.o_mdata   = mdata_q;
  assign bus.o_timeout = to_q;
  assign bus.o_scyc    = scyc_q;
  assign bus.o_sstb    = sstb_q;
  assign bus.o_swe     = swe_q;
  assign bus.o_saddr   = saddr_q;
  assign bus.o_sdata   = sdata_q;
  assign bus.o_ssel    = ssel_q;

endmodule

// File: tb/tb_wb_pico_decoder.sv
// Bench for wb_pico_decoder: vector table of single transactions plus abort and reset sequences.
module tb_wb_pico_decoder;

  localparam int NS = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wb_pico_decoder_if #(.NS(NS)) bus ();

  wb_pico_decoder #(.NS(NS), .TIMEOUT(TO)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  typedef struct {
    logic [29:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          slv;
    int          stall;
    int          resp_cyc;
    logic        r_ack;
    logic        r_err;
    logic [31:0] rdata;
    int          stray;
    logic [3:0]  e_scyc;
    logic        e_ack;
    logic        e_err;
    logic        e_to;
    int          e_lat;
  } vec_t;

  typedef struct {
    logic        ack;
    logic        err;
    logic        to;
    logic [31:0] mdata;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.o_mack || bus.o_merr || bus.o_timeout) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp actual ack=%0b err=%0b to=%0b required none (cycle %0d)",
                 bus.o_mack, bus.o_merr, bus.o_timeout, cyc);
      end else begin
        exp_t r;
        r = sb.pop_front();
        chk("resp_kind", {bus.o_mack, bus.o_merr, bus.o_timeout}, {r.ack, r.err, r.to});
        chk("resp_cycle", cyc, r.cyc);
        if (r.ack) chk("rdata", bus.o_mdata, r.mdata);
      end
    end
  end

  task automatic clear_slaves();
    bus.i_sstall = '0;
    bus.i_sack   = '0;
    bus.i_serr   = '0;
    bus.i_sdata  = '0;
  endtask

  task automatic request(input logic [29:0] a, input logic we, input logic [31:0] d, input logic [3:0] s);
    @(posedge clk); #1;
    bus.i_mcyc  = 1'b1;
    bus.i_mstb  = 1'b1;
    bus.i_maddr = a;
    bus.i_mwe   = we;
    bus.i_mdata = d;
    bus.i_msel  = s;
    @(posedge clk); #1;
    bus.i_mstb = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   acc;
    exp_t e;
    bus.i_sstall = (v.slv >= 0 && v.stall > 0) ? (4'b0001 << v.slv) : 4'b0000;
    request(v.addr, v.we, v.wdata, v.sel);
    acc     = cyc;
    e.ack   = v.e_ack;
    e.err   = v.e_err;
    e.to    = v.e_to;
    e.mdata = v.rdata;
    e.cyc   = acc + v.e_lat - 1;
    sb.push_back(e);
    for (int c = 1; c <= 30; c++) begin
      clear_slaves();
      if (v.slv >= 0 && c <= v.stall) bus.i_sstall[v.slv] = 1'b1;
      if (v.stray >= 0 && c == v.resp_cyc - 1) begin
        bus.i_sack[v.stray]            = 1'b1;
        bus.i_sdata[v.stray*32 +: 32]  = 32'hBAD0_0000;
      end
      if (v.slv >= 0 && c == v.resp_cyc) begin
        bus.i_sack[v.slv]           = v.r_ack;
        bus.i_serr[v.slv]           = v.r_err;
        bus.i_sdata[v.slv*32 +: 32] = v.rdata;
      end
      @(negedge clk);
      if (c == 1) begin
        chk($sformatf("v%0d_saddr", idx), bus.o_saddr, v.addr);
        chk($sformatf("v%0d_swe", idx), bus.o_swe, v.we);
        chk($sformatf("v%0d_ssel", idx), bus.o_ssel, v.sel);
        chk($sformatf("v%0d_sdata", idx), bus.o_sdata, v.wdata);
        chk($sformatf("v%0d_stall", idx), bus.o_mstall, 1'b1);
      end
      if (c < v.e_lat) begin
        chk($sformatf("v%0d_scyc_c%0d", idx, c), bus.o_scyc, v.e_scyc);
        chk($sformatf("v%0d_sstb_c%0d", idx, c), bus.o_sstb, (c <= v.stall + 1) ? v.e_scyc : 4'b0000);
      end else begin
        chk($sformatf("v%0d_scyc_end", idx), bus.o_scyc, 4'b0000);
      end
      @(posedge clk); #1;
      if (c >= v.e_lat) break;
    end
    clear_slaves();
    @(negedge clk);
    chk($sformatf("v%0d_scyc_after", idx), bus.o_scyc, 4'b0000);
    chk($sformatf("v%0d_mstall_after", idx), bus.o_mstall, 1'b0);
    chk($sformatf("v%0d_resp_seen", idx), sb.size(), 0);
    sb.delete();
    @(posedge clk); #1;
    bus.i_mcyc = 1'b0;
  endtask

  initial begin
    vecs[0] = '{30'h0100_0010, 1'b0, 32'h0,    4'hF,    1, 1, 3, 1'b1, 1'b0, 32'hDEAD_BEEF, -1, 4'b0010, 1'b1, 1'b0, 1'b0, 4};
    vecs[1] = '{30'h0200_0105, 1'b1, 32'h1234, 4'b0011, 3, 0, 1, 1'b1, 1'b0, 32'h0,        -1, 4'b1000, 1'b1, 1'b0, 1'b0, 2};
    vecs[2] = '{30'h3000_0000, 1'b0, 32'h0,    4'hF,   -1, 0, 0, 1'b0, 1'b0, 32'h0,        -1, 4'b0000, 1'b0, 1'b1, 1'b0, 2};
    vecs[3] = '{30'h0000_0040, 1'b0, 32'h0,    4'hF,    0, 0, 0, 1'b0, 1'b0, 32'h0,        -1, 4'b0001, 1'b0, 1'b1, 1'b1, TO + 2};
    vecs[4] = '{30'h0200_0004, 1'b0, 32'h0,    4'hF,    2, 0, 3, 1'b1, 1'b1, 32'h1111_2222,  0, 4'b0100, 1'b0, 1'b1, 1'b0, 4};
    vecs[5] = '{30'h0200_01F0, 1'b0, 32'h0,    4'h1,    3, 2, 2, 1'b0, 1'b1, 32'h0,        -1, 4'b1000, 1'b0, 1'b1, 1'b0, 3};
    vecs[6] = '{30'h0000_0100, 1'b0, 32'h0,    4'hF,    0, 0, TO + 1, 1'b1, 1'b0, 32'h5A5A_A5A5, -1, 4'b0001, 1'b1, 1'b0, 1'b0, TO + 2};
    vecs[7] = '{30'h01FF_FFFF, 1'b1, 32'hAB,   4'b1100, 1, 3, 5, 1'b1, 1'b0, 32'hCAFE_F00D, -1, 4'b0010, 1'b1, 1'b0, 1'b0, 6};

    bus.i_mcyc = 1'b0; bus.i_mstb = 1'b0; bus.i_mwe = 1'b0;
    bus.i_maddr = '0; bus.i_mdata = '0; bus.i_msel = '0;
    clear_slaves();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_scyc", bus.o_scyc, 4'b0000);
    chk("rst_sstb", bus.o_sstb, 4'b0000);
    chk("rst_out", {bus.o_mack, bus.o_merr, bus.o_timeout, bus.o_mstall}, 4'b0000);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Master abort during a stalled slave1 access, with a late slave ack that must be dropped.
    bus.i_sstall = 4'b0010;
    request(30'h0100_0000, 1'b0, 32'h0, 4'hF);
    @(negedge clk);
    chk("abort_scyc_c1", bus.o_scyc, 4'b0010);
    @(posedge clk); #1;
    bus.i_mcyc    = 1'b0;
    bus.i_sack[1] = 1'b1;
    @(posedge clk); #1;
    clear_slaves();
    @(negedge clk);
    chk("abort_scyc", bus.o_scyc, 4'b0000);
    chk("abort_sstb", bus.o_sstb, 4'b0000);
    chk("abort_stall", bus.o_mstall, 1'b0);

    // Reset mid-transaction; an ack arriving afterwards is ignored.
    bus.i_sstall = 4'b0010;
    request(30'h0100_0000, 1'b0, 32'h0, 4'hF);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_slaves();
    bus.i_sack[1] = 1'b1;
    @(negedge clk);
    chk("rstmid_scyc", bus.o_scyc, 4'b0000);
    chk("rstmid_sstb", bus.o_sstb, 4'b0000);
    chk("rstmid_stall", bus.o_mstall, 1'b0);
    @(posedge clk); #1;
    clear_slaves();
    @(negedge clk);
    chk("rstmid_resp", {bus.o_mack, bus.o_merr}, 2'b00);
    @(posedge clk); #1;
    bus.i_mcyc = 1'b0;

    run_vec(vecs[0], 8);

    repeat (3) @(posedge clk);
    chk("pending", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_pico_decoder.md
Name: wb_pico_decoder

Overview:
Single-master Wishbone pipelined address decoder with bus-timeout watchdog. It sits directly downstream of the PicoRV32 Wishbone bridge and consumes its cyc/stb/we/addr/data/sel requests. Each request is steered to one of NS slaves, and the ack, err and read data come back to the master. Unmapped addresses and hung slaves are converted to a bus error, so the CPU never deadlocks; that error feeds the CPU's bus-error interrupt.

Parameters:
NS, 4, number of slave ports.
SLAVE_ADDR, {30'h0200_0100, 30'h0200_0000, 30'h0100_0000, 30'h0000_0000}, word-address base per slave; slave k occupies bits [k*30 +: 30].
SLAVE_MASK, {30'h3FFF_FF00, 30'h3FFF_FF00, 30'h3F00_0000, 30'h3F00_0000}, decode mask per slave; same packing.
TIMEOUT, 1023, maximum BUSY cycles before forced error; minimum 2.

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous active-high reset
i_mcyc, i_mstb, i_mwe  in  1 each  master cycle, strobe and write enable
i_maddr  in  30  master word address
i_mdata  in  32  master write data
i_msel  in  4  master byte selects
o_mstall  out  1  master stall
o_mack  out  1  master acknowledge
o_merr  out  1  master bus error
o_mdata  out  32  master read data
o_scyc, o_sstb  out  NS each  per-slave cycle and strobe
o_swe  out  1  shared slave write enable
o_saddr  out  30  shared slave address
o_sdata  out  32  shared slave write data
o_ssel  out  4  shared slave byte selects
i_sstall, i_sack, i_serr  in  NS each  per-slave stall, ack and error
i_sdata  in  NS*32  slave read data, slave k at [k*32 +: 32]
o_timeout  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Clock and reset: one clock, i_clk. Reset is i_reset, synchronous and active-high.
- Reset values: state IDLE. o_scyc, o_sstb, o_mack, o_merr, o_timeout and o_mstall are 0. Counter is 0. Data and address registers are don't-care.
- Decode: slave k matches when (i_maddr & MASK_k) == (ADDR_k & MASK_k). If several slaves match, the lowest index wins. If none matches, the request is unmapped.
- IDLE state:
  - o_mstall = 0.
  - When i_mcyc && i_mstb, the request is accepted. o_saddr, o_sdata, o_ssel and o_swe are registered, and the one-hot select is registered.
  - Mapped request: next cycle o_scyc[k] = 1 and o_sstb[k] = 1, state goes to BUSY.
  - Unmapped request: state goes to ERR.
- BUSY state:
  - o_mstall = 1.
  - o_sstb[k] clears on the first cycle with !i_sstall[k].
  - i_sack[k]: next cycle o_mack = 1 for exactly one cycle and o_mdata = i_sdata[k]. o_scyc clears and state returns to IDLE.
  - i_serr[k]: same timing, but o_merr = 1 instead of o_mack. If ack and err arrive together, err wins.
  - Acks and errs from non-selected slaves are ignored.
  - Watchdog: the counter increments every BUSY cycle. When it reaches TIMEOUT with no ack or err, the next cycle gives o_merr = 1 and o_timeout = 1 (one cycle each), o_scyc and o_sstb clear, and state returns to IDLE.
- ERR state: o_mstall = 1. Next cycle o_merr = 1 for one cycle, then return to IDLE. No slave sees cyc.
- Master abort: if i_mcyc = 0 in BUSY or ERR, all slave cyc/stb clear next cycle, state returns to IDLE, and no ack or err is issued. o_mack and o_merr are always gated by i_mcyc.
- Outstanding requests: one at a time. Latency is: accept at cycle 0, slave stb at cycle 1, master ack at cycle (slave ack) + 1.
- Reset mid-transaction: everything returns to reset values on the next edge. A slave ack arriving afterwards is ignored.
- Counter reloads to 0 on every accept.

Test Plan:
1. Read 0x0100_0010 with slave1 acking at cycle 3 with data 0xDEADBEEF -> o_sstb[1] high for cycles 1..n until !stall, o_mack at cycle 4 with o_mdata = 0xDEADBEEF, o_scyc = 0 at cycle 5.
2. Write 0x0200_0105, sel 4'b0011, data 0x1234 -> only o_scyc[3] asserted, o_swe = 1, o_ssel = 4'b0011, single o_mack.
3. Access 0x3000_0000 (unmapped) -> no o_scyc bit set, o_merr = 1 exactly 2 cycles after accept, o_mack never asserted.
4. Slave0 selected, never acks, TIMEOUT = 8 -> o_merr and o_timeout pulse together, 9 cycles after stb, o_scyc[0] cleared.
5. Slave2 selected; slave0 acks, then slave2 asserts i_sack and i_serr on the same cycle -> stray slave0 ack ignored, o_merr = 1, o_mack = 0.
6. i_mcyc dropped at cycle 2 of a stalled slave1 access, then i_reset asserted mid-transaction -> no ack/err issued, all o_scyc = 0, the next access decodes normally.
